// File: rtl/aq_gemac_tx_ctrl_if.sv
// Byte-stream handshake between the TX buffer and the GEMAC transmit framer.
// The master presents bytes; the slave accepts one on each cycle where S_VALID and S_READY are both high.
interface aq_gemac_tx_ctrl_if;
    logic       S_VALID;
    logic [7:0] S_DATA;
    logic       S_LAST;
    logic       S_READY;

    modport master (output S_VALID, output S_DATA, output S_LAST, input S_READY);
    modport slave  (input S_VALID, input S_DATA, input S_LAST, output S_READY);
endinterface

// File: rtl/aq_gemac_tx_ctrl.sv
// GEMAC transmit framer: preamble, SFD, payload, zero pad, FCS and inter-frame gap onto GMII.
// Sequences the external TX CRC engine; every GMII output is registered one cycle behind the state.
module aq_gemac_tx_ctrl #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic              RST_N,
    input  logic              CLK,
    input  logic              ENABLE,
    aq_gemac_tx_ctrl_if.slave stream,
    output logic              CRC_INIT,
    output logic [7:0]        CRC_DATA,
    output logic              CRC_ENABLE,
    output logic              CRC_RD,
    input  logic [7:0]        CRC_OUT,
    input  logic              CRC_END,
    output logic [7:0]        GMII_TXD,
    output logic              GMII_TX_EN,
    output logic              GMII_TX_ER,
    output logic              TX_BUSY,
    output logic              FRAME_DONE,
    output logic              UNDERRUN
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DRAIN, ST_IFG
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] byte_cnt, byte_cnt_nxt;
    logic [10:0] byte_inc;
    logic [7:0]  phase, phase_nxt;
    logic [7:0]  txd_nxt;
    logic        tx_en_nxt, tx_er_nxt;

    // Frame length counter saturates rather than wrapping on jumbo payloads.
    assign byte_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign TX_BUSY  = (state != ST_IDLE);

    // NOTE: state and wire registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            byte_cnt   <= 11'd0;
            phase      <= 8'd0;
            GMII_TXD   <= 8'h00;
            GMII_TX_EN <= 1'b0;
            GMII_TX_ER <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            phase      <= phase_nxt;
            GMII_TXD   <= txd_nxt;
            GMII_TX_EN <= tx_en_nxt;
            GMII_TX_ER <= tx_er_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        phase_nxt      = phase;
        txd_nxt        = 8'h00;
        tx_en_nxt      = GMII_TX_EN;
        tx_er_nxt      = 1'b0;
        stream.S_READY = 1'b0;
        CRC_INIT       = 1'b0;
        CRC_DATA       = 8'h00;
        CRC_ENABLE     = 1'b0;
        CRC_RD         = 1'b0;
        FRAME_DONE     = 1'b0;
        UNDERRUN       = 1'b0;

        case (state)
            ST_IDLE: begin
                CRC_INIT  = 1'b1;
                tx_en_nxt = 1'b0;
                if (ENABLE && stream.S_VALID) begin
                    txd_nxt   = 8'h55;
                    tx_en_nxt = 1'b1;
                    phase_nxt = 8'd1;
                    state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                txd_nxt   = 8'h55;
                phase_nxt = phase + 8'd1;
                if (phase >= 8'(PREAMBLE_LEN - 1)) state_nxt = ST_SFD;
            end
            ST_SFD: begin
                txd_nxt      = 8'hD5;
                byte_cnt_nxt = 11'd0;
                state_nxt    = ST_DATA;
            end
            ST_DATA: begin
                stream.S_READY = 1'b1;
                if (stream.S_VALID) begin
                    txd_nxt      = stream.S_DATA;
                    CRC_ENABLE   = 1'b1;
                    CRC_DATA     = stream.S_DATA;
                    byte_cnt_nxt = byte_inc;
                    if (stream.S_LAST)
                        state_nxt = (byte_inc < 11'(MIN_FRAME)) ? ST_PAD : ST_FCS;
                end else begin
                    // Starved mid-frame: flag the wire byte as an error and abandon the FCS.
                    tx_er_nxt = 1'b1;
                    UNDERRUN  = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_PAD: begin
                CRC_ENABLE   = 1'b1;
                byte_cnt_nxt = byte_inc;
                if (byte_inc >= 11'(MIN_FRAME)) state_nxt = ST_FCS;
            end
            ST_FCS: begin
                CRC_RD  = 1'b1;
                txd_nxt = CRC_OUT;
                if (CRC_END) begin
                    FRAME_DONE = 1'b1;
                    phase_nxt  = 8'd0;
                    state_nxt  = ST_IFG;
                end
            end
            ST_DRAIN: begin
                tx_en_nxt      = 1'b0;
                stream.S_READY = 1'b1;
                if (stream.S_VALID && stream.S_LAST) begin
                    phase_nxt = 8'd0;
                    state_nxt = ST_IFG;
                end
            end
            ST_IFG: begin
                // IFG_BYTES cycles here; the IDLE decision cycle is the last low cycle on the wire.
                tx_en_nxt = 1'b0;
                phase_nxt = phase + 8'd1;
                if (phase >= 8'(IFG_BYTES - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
